mips_bus_lsu: RTL

Load/store bus unit between the MIPS CPU core and the Avalon memory-mapped bus. It accepts one byte, halfword or word access request at a time from the core and runs the Avalon read or write handshake, including `waitrequest` stalls. For stores it generates `byteenable` and lane-replicated `writedata`. For loads it returns lane-extracted, sign- or zero-extended data.

---
 rtl/mips_bus_pkg.sv | 41 ++++
 rtl/mips_lsu_lane.sv | 45 ++++
 rtl/mips_bus_lsu.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS load/store bus unit and its lane helper.
// The optional misalignment check is enabled by defining MIPS_LSU_ALIGN_CHECK_EN.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUS   = 2'b01,
    RDATA = 2'b10,
    RESP  = 2'b11
  } lsu_state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } lsu_size_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic lsu_size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return SIZE_BYTE;
      2'b01:   return SIZE_HALF;
      default: return SIZE_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_t size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      default:   return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mips_lsu_lane.sv
// Combinational lane logic: byteenable generation, store-data replication and
// load-data extraction with zero/sign extension (little-endian lanes).
module mips_lsu_lane
  import mips_bus_pkg::*;
(
  input  lsu_size_t   size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] rdata_ext
);

  logic [31:0] byte_shifted;
  logic [31:0] half_shifted;

  always_comb begin
    byte_shifted = rdata >> {addr_lo, 3'b000};
    half_shifted = rdata >> {addr_lo[1], 4'b0000};
    byteenable   = BE_WORD;
    writedata    = wdata;
    rdata_ext    = rdata;
    case (size)
      SIZE_BYTE: begin
        byteenable = BE_BYTE0 << addr_lo;
        writedata  = {4{wdata[7:0]}};
        rdata_ext  = {{24{sign_ext & byte_shifted[7]}}, byte_shifted[7:0]};
      end
      // addr_lo[0] is ignored for halfwords; the lane pair is picked by addr_lo[1].
      SIZE_HALF: begin
        byteenable = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        writedata  = {2{wdata[15:0]}};
        rdata_ext  = {{16{sign_ext & half_shifted[15]}}, half_shifted[15:0]};
      end
      default: begin
        byteenable = BE_WORD;
        writedata  = wdata;
        rdata_ext  = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mips_bus_lsu.sv
// Load/store unit bridging the MIPS core to an Avalon-MM master port.
// Define MIPS_LSU_ALIGN_CHECK_EN to fault misaligned halfword/word accesses.
module mips_bus_lsu
  import mips_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
`ifdef MIPS_LSU_ALIGN_CHECK_EN
  output logic        resp_fault,
`endif
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and the unit answers each accepted request
  // with exactly one resp_valid pulse (unless reset intervenes).

  lsu_state_t  state;
  lsu_size_t   size_q;
  logic [1:0]  addr_lo_q;
  logic        signed_q;
  logic        write_q;

  lsu_size_t   req_size_dec;
  lsu_size_t   lane_size;
  logic [1:0]  lane_addr_lo;
  logic        lane_signed;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        req_misaligned;

  assign req_size_dec = decode_size(req_size);

`ifdef MIPS_LSU_ALIGN_CHECK_EN
  logic fault_q;
  assign req_misaligned = is_misaligned(req_size_dec, req_addr[1:0]);
  assign resp_fault     = fault_q;
`else
  assign req_misaligned = 1'b0;
`endif

  // One lane instance serves both directions: the live request in IDLE
  // (for byteenable/writedata capture) and the held request afterwards.
  always_comb begin
    lane_size    = size_q;
    lane_addr_lo = addr_lo_q;
    lane_signed  = signed_q;
    if (state == IDLE) begin
      lane_size    = req_size_dec;
      lane_addr_lo = req_addr[1:0];
      lane_signed  = req_signed;
    end
  end

  mips_lsu_lane u_lane (
    .size       (lane_size),
    .addr_lo    (lane_addr_lo),
    .sign_ext   (lane_signed),
    .wdata      (req_wdata),
    .rdata      (readdata),
    .byteenable (lane_be),
    .writedata  (lane_wdata),
    .rdata_ext  (lane_rdata)
  );

  assign req_ready  = (state == IDLE);
  assign resp_rdata = (state == RDATA) ? lane_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      size_q     <= SIZE_BYTE;
      addr_lo_q  <= 2'b00;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      address    <= 32'h0;
      writedata  <= 32'h0;
      byteenable <= BE_NONE;
      read       <= 1'b0;
      write      <= 1'b0;
      resp_valid <= 1'b0;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            size_q    <= req_size_dec;
            addr_lo_q <= req_addr[1:0];
            signed_q  <= req_signed;
            write_q   <= req_write;
            if (req_misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
              fault_q    <= 1'b1;
`endif
            end else begin
              state      <= BUS;
              address    <= {req_addr[31:2], 2'b00};
              byteenable <= lane_be;
              writedata  <= req_write ? lane_wdata : 32'h0;
              read       <= ~req_write;
              write      <= req_write;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            state      <= write_q ? RESP : RDATA;
            resp_valid <= 1'b1;
            address    <= 32'h0;
            byteenable <= BE_NONE;
            writedata  <= 32'h0;
            read       <= 1'b0;
            write      <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
          fault_q    <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule
